// File: rtl/mem_store_ctrl.sv
// Store-path controller: places store data on byte lanes and issues one or two
// word-aligned write beats, splitting stores that cross a word boundary.
module mem_store_ctrl #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iValid,
  output logic        oReady,
  input  logic [31:0] iAddr,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iData,
  output logic        oMemWrite,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemWData,
  output logic [3:0]  oMemByteEn,
  input  logic        iMemAck,
  output logic        oDone,
  output logic        oError,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Handshake: a request is consumed on a rising edge where oReady=1 and
  // iValid=1; a write beat completes on a rising edge where oMemWrite=1 and
  // iMemAck=1, and all beat fields hold steady until then.

  state_t      state_q, state_d;
  logic [29:0] word_q;
  logic [7:0]  be_q;
  logic [63:0] data_q;
  logic        err_q;

  logic [1:0]  off;
  logic [3:0]  mask;
  logic [31:0] lane_data;
  logic        legal;
  logic        misaligned;
  logic        fault;
  logic [7:0]  be8;
  logic [63:0] data64;

  // Lane placement of the incoming request; unused bytes of rs2 are zeroed so
  // that disabled lanes carry 0.
  always_comb begin
    off        = iAddr[1:0];
    mask       = 4'b0000;
    lane_data  = 32'h0;
    legal      = 1'b1;
    case (iFunct3)
      3'b000:  begin mask = 4'b0001; lane_data = {24'h0, iData[7:0]};  end
      3'b001:  begin mask = 4'b0011; lane_data = {16'h0, iData[15:0]}; end
      3'b010:  begin mask = 4'b1111; lane_data = iData;                end
      default: legal = 1'b0;
    endcase
    misaligned = ((iFunct3 == 3'b001) && off[0]) ||
                 ((iFunct3 == 3'b010) && (off != 2'b00));
    fault      = !legal || (!ALLOW_MISALIGNED && misaligned);
    be8        = {4'b0000, mask} << off;
    data64     = {32'h0, lane_data} << {off, 3'b000};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (iValid) state_d = fault ? RESP : BEAT0;
      BEAT0:   if (iMemAck) state_d = (|be_q[7:4]) ? BEAT1 : RESP;
      BEAT1:   if (iMemAck) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state_q <= IDLE;
      word_q  <= 30'h0;
      be_q    <= 8'h0;
      data_q  <= 64'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && iValid) begin
        word_q <= iAddr[31:2];
        be_q   <= fault ? 8'h0 : be8;
        data_q <= fault ? 64'h0 : data64;
        err_q  <= fault;
      end
    end
  end

  // Outputs depend only on state and captured fields, never on live inputs.
  always_comb begin
    oReady     = (state_q == IDLE);
    oMemWrite  = 1'b0;
    oMemAddr   = 32'h0;
    oMemWData  = 32'h0;
    oMemByteEn = 4'h0;
    oDone      = (state_q == RESP);
    oError     = (state_q == RESP) && err_q;
    dbg_state  = state_q;
    if (state_q == BEAT0) begin
      oMemWrite  = 1'b1;
      oMemAddr   = {word_q, 2'b00};
      oMemWData  = data_q[31:0];
      oMemByteEn = be_q[3:0];
    end else if (state_q == BEAT1) begin
      oMemWrite  = 1'b1;
      oMemAddr   = {word_q + 30'd1, 2'b00};
      oMemWData  = data_q[63:32];
      oMemByteEn = be_q[7:4];
    end
  end

endmodule

// File: tb/tb_mem_store_ctrl.sv
// Directed bench for mem_store_ctrl: one DUT with misaligned stores allowed,
// one with them faulted.
module tb_mem_store_ctrl;

  localparam logic [2:0] F_SB = 3'b000;
  localparam logic [2:0] F_SH = 3'b001;
  localparam logic [2:0] F_SW = 3'b010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, valid_na;
  logic [31:0] addr, data;
  logic [2:0]  funct3;
  logic        ack, ack_na;

  logic        ready, mem_write, done, error;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [1:0]  state;
  logic        ready_na, mem_write_na, done_na, error_na;
  logic [31:0] mem_addr_na, mem_wdata_na;
  logic [3:0]  mem_be_na;
  logic [1:0]  state_na;

  int tests_run = 0;
  int tests_failed = 0;

  // Results of the last run_store call.
  int          nbeats, unstable, done_cnt, err_cnt, wr_cycles, done_lat, rdy_lat;
  logic [31:0] b_addr [4];
  logic [31:0] b_wd   [4];
  logic [3:0]  b_be   [4];

  always #5 clk = ~clk;

  mem_store_ctrl #(.ALLOW_MISALIGNED(1'b1)) dut (
    .iCLK(clk), .iRST_n(rst_n), .iValid(valid), .oReady(ready),
    .iAddr(addr), .iFunct3(funct3), .iData(data),
    .oMemWrite(mem_write), .oMemAddr(mem_addr), .oMemWData(mem_wdata),
    .oMemByteEn(mem_be), .iMemAck(ack), .oDone(done), .oError(error),
    .dbg_state(state)
  );

  mem_store_ctrl #(.ALLOW_MISALIGNED(1'b0)) dut_na (
    .iCLK(clk), .iRST_n(rst_n), .iValid(valid_na), .oReady(ready_na),
    .iAddr(addr), .iFunct3(funct3), .iData(data),
    .oMemWrite(mem_write_na), .oMemAddr(mem_addr_na), .oMemWData(mem_wdata_na),
    .oMemByteEn(mem_be_na), .iMemAck(ack_na), .oDone(done_na), .oError(error_na),
    .dbg_state(state_na)
  );

  // Driver: issues one request to dut, acks each beat after ack_delay wait
  // cycles, and records beats, stability, done/error pulses and latencies
  // (cycle 1 = cycle after the accept edge).
  task automatic run_store(input logic [31:0] a, input logic [2:0] f,
                           input logic [31:0] d, input int ack_delay);
    int  wait_n;
    bit  in_beat;
    nbeats = 0; unstable = 0; done_cnt = 0; err_cnt = 0; wr_cycles = 0;
    done_lat = -1; rdy_lat = -1; wait_n = 0; in_beat = 0;
    @(negedge clk);
    addr = a; funct3 = f; data = d; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (mem_write) begin
        wr_cycles++;
        if (!in_beat) begin
          in_beat = 1; wait_n = 0;
          if (nbeats < 4) begin
            b_addr[nbeats] = mem_addr; b_wd[nbeats] = mem_wdata; b_be[nbeats] = mem_be;
          end
        end else if (nbeats < 4 && (mem_addr !== b_addr[nbeats] ||
                     mem_wdata !== b_wd[nbeats] || mem_be !== b_be[nbeats])) begin
          unstable++;
        end
        if (wait_n == ack_delay) ack = 1'b1;
        wait_n++;
      end
      if (done) begin
        done_cnt++;
        if (done_lat < 0) done_lat = c;
      end
      if (error) err_cnt++;
      if (ready && done_cnt > 0) begin
        rdy_lat = c;
        break;
      end
      @(negedge clk);
      if (ack) begin
        ack = 1'b0; in_beat = 0; nbeats++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; valid_na = 1'b0; ack = 1'b0; ack_na = 1'b0;
    addr = 32'h0; funct3 = 3'h0; data = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (ready !== 1'b1 || mem_write !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: ready=%b write=%b done=%b err=%b, want 1 0 0 0",
               ready, mem_write, done, error);
    end
    tests_run++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_fields: addr=%h wd=%h be=%b, want 0 0 0", mem_addr, mem_wdata, mem_be);
    end
    tests_run++;
    if (ready_na !== 1'b1 || mem_write_na !== 1'b0 || done_na !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_na: ready=%b write=%b done=%b, want 1 0 0", ready_na, mem_write_na, done_na);
    end
  endtask

  task automatic test_sw_aligned();
    run_store(32'h0000_0100, F_SW, 32'hDEAD_BEEF, 0);
    tests_run++;
    if (nbeats !== 1 || b_addr[0] !== 32'h100 || b_be[0] !== 4'b1111 || b_wd[0] !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL sw_aligned_beat: n=%0d addr=%h be=%b wd=%h, want 1 100 1111 deadbeef",
               nbeats, b_addr[0], b_be[0], b_wd[0]);
    end
    tests_run++;
    if (done_lat !== 2 || done_cnt !== 1 || err_cnt !== 0 || rdy_lat !== 3) begin
      tests_failed++;
      $display("FAIL sw_aligned_done: lat=%0d cnt=%0d err=%0d rdy=%0d, want 2 1 0 3",
               done_lat, done_cnt, err_cnt, rdy_lat);
    end
  endtask

  task automatic test_sb();
    run_store(32'h0000_0203, F_SB, 32'h1234_56A5, 0);
    tests_run++;
    if (nbeats !== 1 || b_addr[0] !== 32'h200 || b_be[0] !== 4'b1000 || b_wd[0] !== 32'hA500_0000) begin
      tests_failed++;
      $display("FAIL sb_lane3: n=%0d addr=%h be=%b wd=%h, want 1 200 1000 a5000000",
               nbeats, b_addr[0], b_be[0], b_wd[0]);
    end
    tests_run++;
    if (done_lat !== 2 || err_cnt !== 0) begin
      tests_failed++;
      $display("FAIL sb_done: lat=%0d err=%0d, want 2 0", done_lat, err_cnt);
    end
  endtask

  task automatic test_sh();
    run_store(32'h0000_0302, F_SH, 32'hABCD_1234, 0);
    tests_run++;
    if (nbeats !== 1 || b_addr[0] !== 32'h300 || b_be[0] !== 4'b1100 || b_wd[0] !== 32'h1234_0000) begin
      tests_failed++;
      $display("FAIL sh_upper: n=%0d addr=%h be=%b wd=%h, want 1 300 1100 12340000",
               nbeats, b_addr[0], b_be[0], b_wd[0]);
    end
    run_store(32'h0000_0501, F_SH, 32'h0000_CAFE, 0);
    tests_run++;
    if (nbeats !== 1 || b_addr[0] !== 32'h500 || b_be[0] !== 4'b0110 ||
        b_wd[0] !== 32'h00CA_FE00 || done_lat !== 2 || err_cnt !== 0) begin
      tests_failed++;
      $display("FAIL sh_off1: n=%0d addr=%h be=%b wd=%h lat=%0d err=%0d, want 1 500 0110 00cafe00 2 0",
               nbeats, b_addr[0], b_be[0], b_wd[0], done_lat, err_cnt);
    end
  endtask

  task automatic test_sw_split_delayed();
    run_store(32'h0000_0401, F_SW, 32'h1122_3344, 3);
    tests_run++;
    if (nbeats !== 2 || b_addr[0] !== 32'h400 || b_be[0] !== 4'b1110 || b_wd[0] !== 32'h2233_4400) begin
      tests_failed++;
      $display("FAIL split_beat0: n=%0d addr=%h be=%b wd=%h, want 2 400 1110 22334400",
               nbeats, b_addr[0], b_be[0], b_wd[0]);
    end
    tests_run++;
    if (b_addr[1] !== 32'h404 || b_be[1] !== 4'b0001 || b_wd[1] !== 32'h0000_0011) begin
      tests_failed++;
      $display("FAIL split_beat1: addr=%h be=%b wd=%h, want 404 0001 00000011",
               b_addr[1], b_be[1], b_wd[1]);
    end
    tests_run++;
    if (unstable !== 0 || wr_cycles !== 8 || done_cnt !== 1 || done_lat !== 9 || err_cnt !== 0) begin
      tests_failed++;
      $display("FAIL split_hold: unstable=%0d wr=%0d done=%0d lat=%0d err=%0d, want 0 8 1 9 0",
               unstable, wr_cycles, done_cnt, done_lat, err_cnt);
    end
  endtask

  task automatic test_wrap();
    run_store(32'hFFFF_FFFF, F_SH, 32'h0000_BEEF, 0);
    tests_run++;
    if (nbeats !== 2 || b_addr[0] !== 32'hFFFF_FFFC || b_be[0] !== 4'b1000 || b_wd[0] !== 32'hEF00_0000) begin
      tests_failed++;
      $display("FAIL wrap_beat0: n=%0d addr=%h be=%b wd=%h, want 2 fffffffc 1000 ef000000",
               nbeats, b_addr[0], b_be[0], b_wd[0]);
    end
    tests_run++;
    if (b_addr[1] !== 32'h0 || b_be[1] !== 4'b0001 || b_wd[1] !== 32'h0000_00BE || done_lat !== 3) begin
      tests_failed++;
      $display("FAIL wrap_beat1: addr=%h be=%b wd=%h lat=%0d, want 0 0001 000000be 3",
               b_addr[1], b_be[1], b_wd[1], done_lat);
    end
  endtask

  task automatic test_illegal_funct3();
    run_store(32'h0000_0600, 3'b011, 32'h5555_AAAA, 0);
    tests_run++;
    if (wr_cycles !== 0 || done_lat !== 1 || done_cnt !== 1 || err_cnt !== 1 || rdy_lat !== 2) begin
      tests_failed++;
      $display("FAIL illegal_f3: wr=%0d lat=%0d done=%0d err=%0d rdy=%0d, want 0 1 1 1 2",
               wr_cycles, done_lat, done_cnt, err_cnt, rdy_lat);
    end
  endtask

  task automatic test_ack_ignored();
    int bad;
    bad = 0;
    @(negedge clk);
    ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ready !== 1'b1 || done !== 1'b0 || mem_write !== 1'b0) bad++;
    end
    ack = 1'b0;
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL ack_idle: %0d disturbed cycles, want 0", bad);
    end
  endtask

  task automatic test_no_misaligned();
    int wr_seen;
    wr_seen = 0;
    @(negedge clk);
    addr = 32'h0000_0402; funct3 = F_SW; data = 32'h1111_2222; valid_na = 1'b1;
    @(negedge clk);
    valid_na = 1'b0;
    if (mem_write_na) wr_seen++;
    tests_run++;
    if (done_na !== 1'b1 || error_na !== 1'b1) begin
      tests_failed++;
      $display("FAIL na_sw_fault: done=%b err=%b, want 1 1", done_na, error_na);
    end
    @(negedge clk);
    if (mem_write_na) wr_seen++;
    tests_run++;
    if (ready_na !== 1'b1 || done_na !== 1'b0 || wr_seen !== 0) begin
      tests_failed++;
      $display("FAIL na_sw_after: ready=%b done=%b writes=%0d, want 1 0 0", ready_na, done_na, wr_seen);
    end
    // Aligned halfword in the upper half is still legal here.
    addr = 32'h0000_0402; funct3 = F_SH; data = 32'h0000_7788; valid_na = 1'b1;
    @(negedge clk);
    valid_na = 1'b0;
    tests_run++;
    if (mem_write_na !== 1'b1 || mem_addr_na !== 32'h400 || mem_be_na !== 4'b1100 ||
        mem_wdata_na !== 32'h7788_0000) begin
      tests_failed++;
      $display("FAIL na_sh_ok: write=%b addr=%h be=%b wd=%h, want 1 400 1100 77880000",
               mem_write_na, mem_addr_na, mem_be_na, mem_wdata_na);
    end
    ack_na = 1'b1;
    @(negedge clk);
    ack_na = 1'b0;
    tests_run++;
    if (done_na !== 1'b1 || error_na !== 1'b0) begin
      tests_failed++;
      $display("FAIL na_sh_done: done=%b err=%b, want 1 0", done_na, error_na);
    end
    // Halfword at offset 1 is misaligned and faulted on this instance.
    @(negedge clk);
    addr = 32'h0000_0501; funct3 = F_SH; data = 32'h0000_CAFE; valid_na = 1'b1;
    @(negedge clk);
    valid_na = 1'b0;
    tests_run++;
    if (mem_write_na !== 1'b0 || done_na !== 1'b1 || error_na !== 1'b1) begin
      tests_failed++;
      $display("FAIL na_sh_fault: write=%b done=%b err=%b, want 0 1 1", mem_write_na, done_na, error_na);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_beat();
    int dones;
    dones = 0;
    @(negedge clk);
    addr = 32'h0000_0401; funct3 = F_SW; data = 32'h1122_3344; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    tests_run++;
    if (mem_write !== 1'b1 || mem_addr !== 32'h404) begin
      tests_failed++;
      $display("FAIL rst_mid_setup: write=%b addr=%h, want 1 404", mem_write, mem_addr);
    end
    rst_n = 1'b0;
    @(negedge clk);
    if (done) dones++;
    tests_run++;
    if (mem_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_drop: write=%b, want 0", mem_write);
    end
    @(negedge clk);
    if (done) dones++;
    rst_n = 1'b1;
    @(negedge clk);
    if (done) dones++;
    tests_run++;
    if (ready !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h0 || mem_be !== 4'h0) begin
      tests_failed++;
      $display("FAIL rst_mid_release: ready=%b write=%b addr=%h be=%b, want 1 0 0 0",
               ready, mem_write, mem_addr, mem_be);
    end
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL rst_mid_nodone: %0d done pulses, want 0", dones);
    end
  endtask

  initial begin
    test_reset();
    test_sw_aligned();
    test_sb();
    test_sh();
    test_sw_split_delayed();
    test_wrap();
    test_illegal_funct3();
    test_ack_ignored();
    test_no_misaligned();
    test_reset_mid_beat();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
